// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
// req/gnt request handshake plus an rvalid-qualified response; one request outstanding at a time.
interface if_fetch_unit_if #(
  parameter int Width = 32,
  parameter int Depth = 32
) ();
  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [Depth-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time and presents it to IF/ID
// for one cycle (rvalid -> valid_out next cycle); stall parks the response in a hold buffer.
module if_fetch_unit #(
  parameter int               Width    = 32,
  parameter int               Depth    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [Width-1:0]   redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic [Width-1:0]   Address_out,
  output logic [Depth-1:0]   Instruction_out,
  output logic               valid_out,
  output logic               flush_out
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t           state, state_nxt;
  logic [Width-1:0] pc, pc_nxt;
  logic [Depth-1:0] hold_dat, hold_nxt;
  logic             load;
  logic [Depth-1:0] load_dat;

  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = pc;
  assign flush_out      = rst | redirect | ~valid_out;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold_dat;
    load      = 1'b0;
    load_dat  = '0;
    if (redirect) begin
      // A granted-but-unanswered request must still be drained, hence DROP.
      pc_nxt   = redirect_pc;
      hold_nxt = '0;
      unique case (state)
        S_REQ:   state_nxt = imem.imem_gnt    ? S_DROP : S_REQ;
        S_WAIT:  state_nxt = imem.imem_rvalid ? S_REQ  : S_DROP;
        S_HOLD:  state_nxt = S_REQ;
        S_DROP:  state_nxt = imem.imem_rvalid ? S_REQ  : S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem.imem_gnt) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall) begin
              hold_nxt  = imem.imem_rdata;
              state_nxt = S_HOLD;
            end else begin
              load      = 1'b1;
              load_dat  = imem.imem_rdata;
              pc_nxt    = pc + Width'(4);
              state_nxt = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load      = 1'b1;
            load_dat  = hold_dat;
            pc_nxt    = pc + Width'(4);
            state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_rvalid) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_REQ;
      pc              <= RESET_PC;
      hold_dat        <= '0;
      Address_out     <= '0;
      Instruction_out <= '0;
      valid_out       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      hold_dat  <= hold_nxt;
      valid_out <= load;
      if (load) begin
        Address_out     <= pc;
        Instruction_out <= load_dat;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle vector table for the directed corners, a randomized
// memory with an expected-instruction queue, and a second instance for PC wrap-around.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] address_o, instr_o;
  logic        valid_o, flush_o;

  logic        rst2, stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic [31:0] address_o2, instr_o2;
  logic        valid_o2, flush_o2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit_if #(.Width(32), .Depth(32)) bus ();
  if_fetch_unit_if #(.Width(32), .Depth(32)) bus2 ();

  if_fetch_unit #(.Width(32), .Depth(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(bus.master), .Address_out(address_o), .Instruction_out(instr_o),
    .valid_out(valid_o), .flush_out(flush_o)
  );

  if_fetch_unit #(.Width(32), .Depth(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .imem(bus2.master), .Address_out(address_o2), .Instruction_out(instr_o2),
    .valid_out(valid_o2), .flush_out(flush_o2)
  );

  typedef struct {
    string       name;
    logic        rst, stall, redirect;
    logic [31:0] rpc;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_aout, e_iout;
    logic        e_flush;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  logic exp_pulse;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic g, input logic rv, input logic [31:0] dat,
                     input logic ereq, input logic [31:0] eaddr, input logic evld,
                     input logic [31:0] eaout, input logic [31:0] eiout, input logic efl);
    vec_t v;
    v.name = nm; v.rst = r; v.stall = st; v.redirect = rd; v.rpc = rpc;
    v.gnt = g; v.rvalid = rv; v.rdata = dat;
    v.e_req = ereq; v.e_addr = eaddr; v.e_vld = evld;
    v.e_aout = eaout; v.e_iout = eiout; v.e_flush = efl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] dat);
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_pc = rpc;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = dat;
    #1;
  endtask

  // One scoreboard cycle: every presentation must be expected and must match the queue head.
  task automatic sb_cycle(input logic g, input logic rv, input logic st, input logic [31:0] dat);
    exp_t e;
    drive(1'b0, st, 1'b0, 32'h0, g, rv, dat);
    chk("sb_valid_timing", {31'b0, valid_o}, {31'b0, exp_pulse});
    exp_pulse = 1'b0;
    if (valid_o) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected actual=%h required=none", address_o);
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", address_o, e.addr);
        chk("sb_instr", instr_o, e.instr);
      end
    end
  endtask

  initial begin
    logic [31:0] n_i, d_i, exp_pc, dat;
    int k, dly, stl;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    rst2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
    exp_pulse = 1'b0;

    n_i = 32'h0050_0093;
    d_i = 32'hDEAD_BEEF;
    //   name          rst st rd rpc       gnt rv rdata          req addr    vld aout      iout           flush
    add("reset_state", 0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h0,   0, 32'h0,   32'h0,         1);
    add("f0_wait",     0, 0, 0, 32'h0,   0, 1, n_i,            0, 32'h0,   0, 32'h0,   32'h0,         1);
    add("f0_pulse",    0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h4,   1, 32'h0,   n_i,           0);
    add("f1_wait",     0, 0, 0, 32'h0,   0, 1, n_i,            0, 32'h4,   0, 32'h0,   n_i,           1);
    add("f1_pulse",    0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h8,   1, 32'h4,   n_i,           0);
    add("f2_wait",     0, 0, 0, 32'h0,   0, 1, n_i,            0, 32'h8,   0, 32'h4,   n_i,           1);
    add("f2_pulse",    0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'hC,   1, 32'h8,   n_i,           0);
    add("stall_rv",    0, 1, 0, 32'h0,   1, 1, d_i,            0, 32'hC,   0, 32'h8,   n_i,           1);
    add("stall_2",     0, 1, 0, 32'h0,   1, 1, 32'h0BAD_0BAD,  0, 32'hC,   0, 32'h8,   n_i,           1);
    add("stall_3",     0, 1, 0, 32'h0,   1, 0, 32'h0,          0, 32'hC,   0, 32'h8,   n_i,           1);
    add("stall_rel",   0, 0, 0, 32'h0,   0, 0, 32'h0,          0, 32'hC,   0, 32'h8,   n_i,           1);
    add("held_pulse",  0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h10,  1, 32'hC,   d_i,           0);
    add("redir_wait",  0, 0, 1, 32'h100, 0, 0, 32'h0,          0, 32'h10,  0, 32'hC,   d_i,           1);
    add("drop_1",      0, 0, 0, 32'h0,   1, 0, 32'h0,          0, 32'h100, 0, 32'hC,   d_i,           1);
    add("drop_stale",  0, 0, 0, 32'h0,   0, 1, 32'h1111_1111,  0, 32'h100, 0, 32'hC,   d_i,           1);
    add("req_target",  0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h100, 0, 32'hC,   d_i,           1);
    add("redir_rv",    0, 0, 1, 32'h200, 0, 1, 32'hAAAA_0001,  0, 32'h100, 0, 32'hC,   d_i,           1);
    add("redir_gnt",   0, 0, 1, 32'h300, 1, 0, 32'h0,          1, 32'h200, 0, 32'hC,   d_i,           1);
    add("drop_gnt",    0, 0, 0, 32'h0,   0, 1, 32'h5555_5555,  0, 32'h300, 0, 32'hC,   d_i,           1);
    add("req_300",     0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h300, 0, 32'hC,   d_i,           1);
    add("wait_300",    0, 0, 0, 32'h0,   0, 1, 32'h1234_5678,  0, 32'h300, 0, 32'hC,   d_i,           1);
    add("pulse_300",   0, 0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h304, 1, 32'h300, 32'h1234_5678, 0);
    add("rst_in_wait", 1, 1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h304, 0, 32'h300, 32'h1234_5678, 1);
    add("after_rst",   0, 0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h0,   0, 32'h0,   32'h0,         1);

    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc,
            vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      chk({vecs[i].name, ".req"},   {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
      chk({vecs[i].name, ".addr"},  bus.imem_addr,         vecs[i].e_addr);
      chk({vecs[i].name, ".valid"}, {31'b0, valid_o},      {31'b0, vecs[i].e_vld});
      chk({vecs[i].name, ".aout"},  address_o,             vecs[i].e_aout);
      chk({vecs[i].name, ".iout"},  instr_o,               vecs[i].e_iout);
      chk({vecs[i].name, ".flush"}, {31'b0, flush_o},      {31'b0, vecs[i].e_flush});
    end

    // Randomized memory timing and stalls; the bench tracks the PC independently.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_pc = 32'h0;
    for (int n = 0; n < 20; n++) begin
      sb_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      k = 0;
      while (!bus.imem_req && k < 8) begin
        sb_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        k++;
      end
      chk("sb_req", {31'b0, bus.imem_req}, 32'h1);
      chk("sb_req_addr", bus.imem_addr, exp_pc);
      dly = $urandom_range(0, 2);
      repeat (dly) sb_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      sb_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      dly = $urandom_range(0, 2);
      repeat (dly) sb_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      dat = $urandom;
      stl = $urandom_range(0, 3);
      sb_cycle(1'b0, 1'b1, (stl != 0), dat);
      sb_q.push_back('{addr: exp_pc, instr: dat});
      exp_pc = exp_pc + 32'h4;
      if (stl != 0) begin
        repeat (stl - 1) sb_cycle(1'b0, 1'b0, 1'b1, 32'h0);
        sb_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      end
      exp_pulse = 1'b1;
    end
    repeat (3) sb_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("sb_drained", sb_q.size(), 32'h0);

    // PC wrap on the second instance.
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk); rst2 = 1'b0; bus2.imem_gnt = 1'b1; #1;
    chk("wrap_req_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'hCAFE_F00D;
    @(negedge clk); bus2.imem_rvalid = 1'b0; #1;
    chk("wrap_valid", {31'b0, valid_o2}, 32'h1);
    chk("wrap_aout", address_o2, 32'hFFFF_FFFC);
    chk("wrap_iout", instr_o2, 32'hCAFE_F00D);
    chk("wrap_next_addr", bus2.imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
